// File: rtl/score_recorder.sv
// Live score recorder: samples the note/scale switches once per beat and packs
// them into the nibble-per-position score format used by the playback core.
module score_recorder #(
    parameter int BEAT_CYCLES = 30000000,
    parameter int MAX_NOTES   = 75
) (
    input  logic         clk100mhz,
    input  logic         clr,
    input  logic         rec_en,
    input  logic [3:0]   single_music,
    input  logic [1:0]   single_md,
    output logic [300:0] rhyme,
    output logic [300:0] md,
    output logic [7:0]   how_long,
    output logic         recording,
    output logic         full,
    output logic         beat
);
    localparam int              BC_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEAT_CYCLES - 1);
    localparam logic [7:0]      CAP     = 8'(MAX_NOTES);

    typedef enum logic [1:0] {IDLE, REC, DONE} state_t;

    state_t          state;
    logic            rec_q;
    logic [BC_W-1:0] bc;
    logic            start;
    logic            sample;
    logic [3:0]      note_nib;
    logic [3:0]      md_nib;
    logic            unused_music_bit3;

    assign unused_music_bit3 = single_music[3];
    assign start             = rec_en & ~rec_q;
    assign sample            = (state == REC) && rec_en && (bc == BC_LAST);

    // An invalid scale code is recorded as a rest.
    always_comb begin
        note_nib = {1'b0, single_music[2:0]};
        md_nib   = {2'b00, single_md};
        if (single_md == 2'd3) begin
            note_nib = 4'd0;
            md_nib   = 4'd0;
        end
    end

    always_ff @(posedge clk100mhz) begin
        // rec_q keeps following rec_en through clr, so a level held across clr
        // is not mistaken for a fresh rising edge.
        rec_q <= rec_en;
        if (clr) begin
            // NOTE: the packed score is a register bank, not a RAM, so it is cleared by clr.
            state     <= IDLE;
            rhyme     <= '0;
            md        <= '0;
            how_long  <= '0;
            recording <= 1'b0;
            full      <= 1'b0;
            beat      <= 1'b0;
            bc        <= '0;
        end else begin
            beat <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= REC;
                        recording <= 1'b1;
                        rhyme     <= '0;
                        md        <= '0;
                        how_long  <= '0;
                        full      <= 1'b0;
                        bc        <= '0;
                    end
                end
                REC: begin
                    if (!rec_en) begin
                        state     <= DONE;
                        recording <= 1'b0;
                    end else begin
                        bc <= (bc == BC_LAST) ? '0 : bc + BC_W'(1);
                        if (sample) begin
                            // Only positions below MAX_NOTES are ever addressed.
                            for (int p = 0; p < MAX_NOTES; p++) begin
                                if (how_long == 8'(p)) begin
                                    rhyme[4*p +: 4] <= note_nib;
                                    md[4*p +: 4]    <= md_nib;
                                end
                            end
                            how_long <= how_long + 8'd1;
                            beat     <= 1'b1;
                            if (how_long + 8'd1 == CAP) begin
                                full      <= 1'b1;
                                recording <= 1'b0;
                                state     <= DONE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
